// File: rtl/raizing_snd_mailbox.sv
// raizing_snd_mailbox
//   Bidirectional 68K <-> Z80 sound mailbox. There are CHANNELS independent
//   FIFOs per direction: main->sub (68K writes, Z80 reads) and sub->main
//   (Z80 writes, 68K reads). Each FIFO reports occupancy, full and a sticky
//   overflow flag. Level interrupts go to both CPUs.
//
//   Optional feature, macro RAIZING_MAILBOX_NMI_EN:
//     a successful main write to channel NMI_CH raises NMI for NMI_LEN
//     cycles. A further qualifying write reloads the counter. When the
//     macro is not defined, NMI is tied low.
//
// Ports
//   CLK, RESET                 system clock, async active-high reset
//   MAIN_WR/RD/CLR, MAIN_CH    68K strobes and channel select
//   MAIN_DIN / MAIN_DOUT       68K write data / registered read data
//   SUB_WR/RD/CLR, SUB_CH      Z80 strobes and channel select
//   SUB_DIN / SUB_DOUT         Z80 write data / registered read data
//   MAIN_AVAIL / SUB_AVAIL     non-empty flags of sub->main / main->sub
//   MAIN_FULL / SUB_FULL       full flags of main->sub / sub->main
//   MAIN_OVF / SUB_OVF         sticky dropped-write flags of main / sub writes
//                              (cleared by the reading side's CLR strobe)
//   SUB_IRQ, MAIN_IRQ, NMI     interrupt outputs
module raizing_snd_mailbox #(
  parameter int unsigned          CHANNELS     = 4,
  parameter int unsigned          DW           = 8,
  parameter int unsigned          DEPTH        = 4,
  parameter logic [CHANNELS-1:0]  SUB_IRQ_MASK = {CHANNELS{1'b1}},
  parameter int unsigned          NMI_CH       = 0,
  parameter int unsigned          NMI_LEN      = 16,
  localparam int unsigned         CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                MAIN_WR,
  input  logic                MAIN_RD,
  input  logic [CW-1:0]       MAIN_CH,
  input  logic [DW-1:0]       MAIN_DIN,
  output logic [DW-1:0]       MAIN_DOUT,
  input  logic                MAIN_CLR,
  input  logic                SUB_WR,
  input  logic                SUB_RD,
  input  logic [CW-1:0]       SUB_CH,
  input  logic [DW-1:0]       SUB_DIN,
  output logic [DW-1:0]       SUB_DOUT,
  input  logic                SUB_CLR,
  output logic [CHANNELS-1:0] MAIN_AVAIL,
  output logic [CHANNELS-1:0] SUB_AVAIL,
  output logic [CHANNELS-1:0] MAIN_FULL,
  output logic [CHANNELS-1:0] SUB_FULL,
  output logic [CHANNELS-1:0] MAIN_OVF,
  output logic [CHANNELS-1:0] SUB_OVF,
  output logic                SUB_IRQ,
  output logic                MAIN_IRQ,
  output logic                NMI
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  if (CHANNELS == 0 || CHANNELS > 8 || DEPTH == 0 || DEPTH > 16 ||
      (DEPTH & (DEPTH - 1)) != 0 || NMI_CH >= CHANNELS || NMI_LEN == 0) begin : g_param_check
    $error("raizing_snd_mailbox: illegal parameter set");
  end

  // Direction index: 0 = main->sub, 1 = sub->main.
  logic [DW-1:0]       mem_q    [2][CHANNELS][DEPTH];
  logic [DW-1:0]       mem_d    [2][CHANNELS][DEPTH];
  logic [AW-1:0]       wr_ptr_q [2][CHANNELS];
  logic [AW-1:0]       wr_ptr_d [2][CHANNELS];
  logic [AW-1:0]       rd_ptr_q [2][CHANNELS];
  logic [AW-1:0]       rd_ptr_d [2][CHANNELS];
  logic [CNTW-1:0]     cnt_q    [2][CHANNELS];
  logic [CNTW-1:0]     cnt_d    [2][CHANNELS];
  logic [CHANNELS-1:0] ovf_q    [2];
  logic [CHANNELS-1:0] ovf_d    [2];
  logic [DW-1:0]       dout_q   [2];
  logic [DW-1:0]       dout_d   [2];
  logic                sub_irq_q, sub_irq_d;
  logic                main_irq_q, main_irq_d;

  logic [CHANNELS-1:0] avail [2];
  logic [CHANNELS-1:0] full  [2];
  logic [CHANNELS-1:0] push  [2];

  // Per-direction view of the strobes: who writes, who reads, who clears.
  logic                wr_en  [2];
  logic                rd_en  [2];
  logic                clr_en [2];
  logic [CW-1:0]       wr_ch  [2];
  logic [CW-1:0]       rd_ch  [2];
  logic [CW-1:0]       clr_ch [2];
  logic [DW-1:0]       din    [2];
  logic                main_ch_ok, sub_ch_ok;

  assign main_ch_ok = (32'(MAIN_CH) < CHANNELS);
  assign sub_ch_ok  = (32'(SUB_CH) < CHANNELS);

  assign wr_en[0]  = MAIN_WR & main_ch_ok;
  assign wr_ch[0]  = MAIN_CH;
  assign din[0]    = MAIN_DIN;
  assign rd_en[0]  = SUB_RD & sub_ch_ok;
  assign rd_ch[0]  = SUB_CH;
  assign clr_en[0] = SUB_CLR & sub_ch_ok;
  assign clr_ch[0] = SUB_CH;

  assign wr_en[1]  = SUB_WR & sub_ch_ok;
  assign wr_ch[1]  = SUB_CH;
  assign din[1]    = SUB_DIN;
  assign rd_en[1]  = MAIN_RD & main_ch_ok;
  assign rd_ch[1]  = MAIN_CH;
  assign clr_en[1] = MAIN_CLR & main_ch_ok;
  assign clr_ch[1] = MAIN_CH;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      avail[d] = '0;
      full[d]  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        avail[d][c] = (cnt_q[d][c] != '0);
        full[d][c]  = (cnt_q[d][c] == CNTW'(DEPTH));
      end
    end
  end

  always_comb begin
    logic wr_hit, rd_hit, do_rd, do_wr;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    dout_d   = dout_q;
    push[0]  = '0;
    push[1]  = '0;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_hit = wr_en[d] && (wr_ch[d] == CW'(c));
        rd_hit = rd_en[d] && (rd_ch[d] == CW'(c));
        do_rd  = rd_hit && avail[d][c];
        // A read in the same cycle frees the slot, so a write to a full FIFO
        // still lands. An empty FIFO never forwards the incoming word.
        do_wr  = wr_hit && (!full[d][c] || do_rd);
        if (do_wr) begin
          mem_d[d][c][wr_ptr_q[d][c]] = din[d];
          wr_ptr_d[d][c] = ptr_inc(wr_ptr_q[d][c]);
        end
        if (do_rd) begin
          dout_d[d] = mem_q[d][c][rd_ptr_q[d][c]];
          rd_ptr_d[d][c] = ptr_inc(rd_ptr_q[d][c]);
        end
        if (do_wr && !do_rd) begin
          cnt_d[d][c] = cnt_q[d][c] + CNTW'(1);
        end else if (do_rd && !do_wr) begin
          cnt_d[d][c] = cnt_q[d][c] - CNTW'(1);
        end
        if (clr_en[d] && (clr_ch[d] == CW'(c))) begin
          ovf_d[d][c] = 1'b0;
        end
        // Set after clear so a coincident overflow wins.
        if (wr_hit && !do_wr) begin
          ovf_d[d][c] = 1'b1;
        end
        push[d][c] = do_wr;
      end
    end
    sub_irq_d  = |(avail[0] & SUB_IRQ_MASK);
    main_irq_d = |avail[1];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '{default: '0};
      rd_ptr_q   <= '{default: '0};
      cnt_q      <= '{default: '0};
      ovf_q      <= '{default: '0};
      dout_q     <= '{default: '0};
      sub_irq_q  <= 1'b0;
      main_irq_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      dout_q     <= dout_d;
      sub_irq_q  <= sub_irq_d;
      main_irq_q <= main_irq_d;
    end
  end

  assign SUB_DOUT   = dout_q[0];
  assign MAIN_DOUT  = dout_q[1];
  assign SUB_AVAIL  = avail[0];
  assign MAIN_AVAIL = avail[1];
  assign MAIN_FULL  = full[0];
  assign SUB_FULL   = full[1];
  assign MAIN_OVF   = ovf_q[0];
  assign SUB_OVF    = ovf_q[1];
  assign SUB_IRQ    = sub_irq_q;
  assign MAIN_IRQ   = main_irq_q;

`ifdef RAIZING_MAILBOX_NMI_EN
  localparam int unsigned NW = $clog2(NMI_LEN + 1);
  logic [NW-1:0] nmi_cnt_q, nmi_cnt_d;
  logic          nmi_q, nmi_d;
  logic          unused_push;

  assign unused_push = |push[1];

  always_comb begin
    nmi_cnt_d = nmi_cnt_q;
    if (push[0][NMI_CH]) begin
      nmi_cnt_d = NW'(NMI_LEN);
    end else if (nmi_cnt_q != '0) begin
      nmi_cnt_d = nmi_cnt_q - NW'(1);
    end
    nmi_d = (nmi_cnt_d != '0);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      nmi_cnt_q <= '0;
      nmi_q     <= 1'b0;
    end else begin
      nmi_cnt_q <= nmi_cnt_d;
      nmi_q     <= nmi_d;
    end
  end

  assign NMI = nmi_q;
`else
  logic unused_push;
  assign unused_push = |{push[0], push[1]};
  assign NMI = 1'b0;
`endif

endmodule

// File: doc/raizing_snd_mailbox.md
Name: raizing_snd_mailbox

Overview:
- Parametrised successor to the fixed four-register 68K↔Z80 sound-latch scheme.
- Provides CHANNELS independent FIFO mailboxes in each direction: main→sub (68K to Z80) and sub→main (Z80 to 68K).
- Each mailbox has per-channel occupancy, overflow status and maskable interrupt generation.
- Sits between the 68K CPU block and the sound block, in the 48 MHz domain.

Parameters:
- CHANNELS, 4, number of mailboxes per direction (1..8).
- DW, 8, data width of each entry.
- DEPTH, 4, entries per mailbox FIFO; power of two, 1..16.
- SUB_IRQ_MASK, 4'b1111, main→sub channels whose non-empty state drives SUB_IRQ (width CHANNELS).
- NMI_CH, 0, main→sub channel whose write raises NMI (optional feature only).
- NMI_LEN, 16, NMI pulse length in CLK cycles.

Ports:
- CLK  in  1  system clock (48 MHz).
- RESET  in  1  asynchronous, active-high reset.
- MAIN_WR  in  1  one-cycle strobe: push MAIN_DIN into main→sub FIFO[MAIN_CH].
- MAIN_RD  in  1  one-cycle strobe: pop sub→main FIFO[MAIN_CH].
- MAIN_CH  in  clog2(CHANNELS) (min 1)  channel select for the main side.
- MAIN_DIN  in  DW  write data from the main side.
- MAIN_DOUT  out  DW  registered read data for the main side.
- MAIN_CLR  in  1  one-cycle strobe: clear the sub→main overflow flag of MAIN_CH.
- SUB_WR, SUB_RD, SUB_CH, SUB_DIN, SUB_DOUT, SUB_CLR  same as the MAIN_ ports, mirrored for the sub side.
- MAIN_AVAIL  out  CHANNELS  sub→main FIFO non-empty flags.
- SUB_AVAIL  out  CHANNELS  main→sub FIFO non-empty flags.
- MAIN_FULL  out  CHANNELS  main→sub FIFO full flags (back-pressure to the 68K).
- SUB_FULL  out  CHANNELS  sub→main FIFO full flags.
- MAIN_OVF  out  CHANNELS  sticky: main write dropped because the FIFO was full.
- SUB_OVF  out  CHANNELS  sticky: sub write dropped because the FIFO was full.
- SUB_IRQ  out  1  level interrupt to the Z80.
- MAIN_IRQ  out  1  level interrupt to the 68K: OR of MAIN_AVAIL.
- NMI  out  1  NMI to the Z80 (driven 0 when the optional feature is absent).

Behaviour:
- Reset (asynchronous): all FIFO pointers and counts 0; all *_DOUT, *_OVF, *_IRQ and NMI are 0; *_AVAIL are 0; *_FULL are 0 (they are 1 only if DEPTH==1 and the FIFO holds an entry).
- Storage: each FIFO is a circular buffer with rd_ptr, wr_ptr (log2 DEPTH bits, natural wrap) and count (log2 DEPTH + 1 bits).
- Write, not full: data stored at wr_ptr; wr_ptr++ and count++ on the same edge. AVAIL goes high the next cycle.
- Write, full (and no read on the same FIFO): data dropped, pointers unchanged, OVF[ch] set the next cycle.
- Read, not empty: *_DOUT <= mem[rd_ptr]; rd_ptr++, count--. DOUT is valid 1 cycle after the RD strobe.
- Read, empty: DOUT holds its previous value; pointers unchanged; no error flag.
- Read and write on the same FIFO in the same cycle:
  - Both take effect and count is unchanged.
  - If the FIFO was full, the write succeeds with no OVF.
  - If the FIFO was empty, the write is stored, the read behaves as an empty read, and there is no bypass.
- MAIN_CH and SUB_CH are sampled only with a strobe. A channel index ≥ CHANNELS is ignored: no state change, DOUT held.
- CLR clears OVF[ch] the next cycle. If CLR and a new overflow coincide on the same channel, the set wins.
- SUB_IRQ = |(SUB_AVAIL & SUB_IRQ_MASK), registered, with 1-cycle latency from the count change.
- MAIN_IRQ = |MAIN_AVAIL, registered.
- Strobes are assumed to be single-cycle; a held strobe acts on every cycle it is high.
- RESET asserted mid-transfer clears everything immediately; no partial write survives.

Optional Feature:
- Macro RAIZING_MAILBOX_NMI_EN.
- Defined:
  - A successful MAIN_WR to NMI_CH loads a counter with NMI_LEN.
  - NMI = (counter != 0), registered; the counter decrements each cycle.
  - A new qualifying write during a pulse reloads the counter, extending the pulse.
  - A dropped (overflow) write does not trigger NMI.
- Undefined: NMI is tied to 0 and the counter logic is absent.

Test Plan:
- Reset, then MAIN_WR ch1 = 0x5A → SUB_AVAIL = 0010 the next cycle; SUB_IRQ = 1 one cycle later; SUB_RD ch1 → SUB_DOUT = 0x5A, SUB_AVAIL = 0000.
- Five MAIN_WR to ch0 with data 1..5 at DEPTH=4 → MAIN_FULL[0] = 1 after the 4th; MAIN_OVF[0] = 1 after the 5th; four SUB_RD return 1, 2, 3, 4.
- FIFO ch2 full; MAIN_WR 0x77 and SUB_RD in the same cycle → no OVF; count stays 4; the fourth subsequent read returns 0x77.
- SUB_RD on empty ch3 after a prior read of 0x33 → SUB_DOUT stays 0x33; pointers are unchanged.
- Write 0x10 to ch0 pointer wrap: 20 write/read pairs → data order preserved and the last value read is correct.
- With RAIZING_MAILBOX_NMI_EN: MAIN_WR ch0, then a second write 5 cycles later → NMI high for 5 + 16 cycles continuously; without the macro, NMI stays 0.
